bidir_buffer: RTL and testbench

Clocked, direction-controlled bidirectional bus buffer connecting two shared tristate nets, side A and side B. When `sel` is 1 side A drives side B; when `sel` is 0 side B drives side A. A registered direction state machine ensures both sides are never driven at once: every direction reversal inserts a turnaround gap during which both sides are released. The block sits at board/pad-level bus bridges and bidirectional port interfaces.

---
 rtl/bidir_buffer_pkg.sv | 17 +
 rtl/bidir_buffer_ctrl.sv | 84 ++++++++
 rtl/bidir_buffer.sv | 44 ++++
 tb/tb_bidir_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bidir_buffer_pkg.sv
// Shared definitions for the bidirectional bus buffer.
//   state_t  : direction state machine encoding (OFF, A2B, B2A, TURN)
//   DIR_A2B  : value of sel requesting side A -> side B
//   DIR_B2A  : value of sel requesting side B -> side A
package bidir_buffer_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        A2B  = 2'd1,
        B2A  = 2'd2,
        TURN = 2'd3
    } state_t;

    localparam logic DIR_A2B = 1'b1;
    localparam logic DIR_B2A = 1'b0;

endpackage

// File: rtl/bidir_buffer_ctrl.sv
// Direction controller for the bidirectional bus buffer.
// Holds the direction state machine and the turnaround counter, and
// produces registered, mutually exclusive drive enables.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (forces OFF)
//   sel    : requested direction, DIR_A2B / DIR_B2A
//   en     : buffer enable, 0 releases both sides
//   oe_ab  : 1 while side B is driven from side A
//   oe_ba  : 1 while side A is driven from side B
//   busy   : 1 during the turnaround gap
module bidir_buffer_ctrl
    import bidir_buffer_pkg::*;
#(
    parameter int TURN_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sel,
    input  logic en,
    output logic oe_ab,
    output logic oe_ba,
    output logic busy
);

    localparam int CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURN_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    function automatic state_t dir_state(input logic s);
        return (s == DIR_A2B) ? A2B : B2A;
    endfunction

    // Reversal always goes through TURN; leaving OFF needs no gap because
    // nothing is driven there. TURN re-samples sel on exit.
    function automatic state_t next_state(input state_t st, input logic e,
                                          input logic s, input logic [CNT_W-1:0] c);
        state_t nxt;
        nxt = st;
        if (!e) begin
            nxt = OFF;
        end else begin
            case (st)
                OFF:     nxt = dir_state(s);
                A2B:     if (s != DIR_A2B) nxt = TURN;
                B2A:     if (s != DIR_B2A) nxt = TURN;
                TURN:    if (c == '0) nxt = dir_state(s);
                default: nxt = OFF;
            endcase
        end
        return nxt;
    endfunction

    assign state_nxt = next_state(state, en, sel, cnt);

    // Outputs are registered from the next state so they always equal a
    // decode of the current state, with no combinational glitch path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            cnt   <= '0;
            oe_ab <= 1'b0;
            oe_ba <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            oe_ab <= (state_nxt == A2B);
            oe_ba <= (state_nxt == B2A);
            busy  <= (state_nxt == TURN);
            if (state_nxt == TURN) begin
                if (state != TURN) begin
                    cnt <= CNT_LOAD;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bidir_buffer.sv
// Clocked, direction-controlled bidirectional bus buffer between two
// shared tristate nets. The controller guarantees the two sides are never
// driven together; the data path itself is purely combinational.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   a, b   : bidirectional sides, WIDTH bits each
//   sel    : requested direction, 1 = A->B, 0 = B->A
//   en     : buffer enable, 0 releases both sides
//   oe_ab  : 1 while b is driven from a
//   oe_ba  : 1 while a is driven from b
//   busy   : 1 during the turnaround gap
module bidir_buffer
    import bidir_buffer_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic             oe_ab,
    output logic             oe_ba,
    output logic             busy
);

    bidir_buffer_ctrl #(
        .TURN_CYCLES(TURN_CYCLES)
    ) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .en    (en),
        .oe_ab (oe_ab),
        .oe_ba (oe_ba),
        .busy  (busy)
    );

    assign b = oe_ab ? a : {WIDTH{1'bz}};
    assign a = oe_ba ? b : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bidir_buffer.sv
// Testbench for bidir_buffer: two instances (turnaround 1 and 3 cycles)
// share clock, reset, en and sel; each has its own pair of bus nets.
module tb_bidir_buffer;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, en, sel;
    logic [W-1:0] da, db;
    logic         a1_en, b1_en, a3_en, b3_en;
    wire  [W-1:0] a1, b1, a3, b3;
    logic         oe_ab1, oe_ba1, busy1, oe_ab3, oe_ba3, busy3;

    assign a1 = a1_en ? da : {W{1'bz}};
    assign b1 = b1_en ? db : {W{1'bz}};
    assign a3 = a3_en ? da : {W{1'bz}};
    assign b3 = b3_en ? db : {W{1'bz}};

    bidir_buffer #(.WIDTH(W), .TURN_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel), .en(en),
        .oe_ab(oe_ab1), .oe_ba(oe_ba1), .busy(busy1));

    bidir_buffer #(.WIDTH(W), .TURN_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .sel(sel), .en(en),
        .oe_ab(oe_ab3), .oe_ba(oe_ba3), .busy(busy3));

    int checks   = 0;
    int failures = 0;

    // Reference model: drive direction (+1 A->B, -1 B->A, 0 none) and the
    // number of released cycles still owed by a pending reversal.
    int m_drv[2];
    int m_gap[2];

    function automatic int tc_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_drv[i] = 0;
            m_gap[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || !en) begin
                m_drv[i] = 0;
                m_gap[i] = 0;
            end else if (m_gap[i] > 0) begin
                m_gap[i] = m_gap[i] - 1;
                if (m_gap[i] == 0) m_drv[i] = sel ? 1 : -1;
            end else if (m_drv[i] == 0) begin
                m_drv[i] = sel ? 1 : -1;
            end else if ((m_drv[i] == 1) != sel) begin
                m_drv[i] = 0;
                m_gap[i] = tc_of(i);
            end
        end
    endtask

    function automatic logic [2:0] exp_flags(input int i);
        return {m_drv[i] == 1, m_drv[i] == -1, m_gap[i] > 0};
    endfunction

    function automatic logic [2:0] obs_flags(input int i);
        return (i == 0) ? {oe_ab1, oe_ba1, busy1} : {oe_ab3, oe_ba3, busy3};
    endfunction

    // External agents drive only the side the buffer is not driving; when
    // the buffer drives nothing they drive the source side of sel.
    task automatic apply_ext();
        a1_en = (m_drv[0] == 1)  || (m_drv[0] == 0 && sel);
        b1_en = (m_drv[0] == -1) || (m_drv[0] == 0 && !sel);
        a3_en = (m_drv[1] == 1)  || (m_drv[1] == 0 && sel);
        b3_en = (m_drv[1] == -1) || (m_drv[1] == 0 && !sel);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        apply_ext();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; sel = 1'b1; da = 4'h5; db = 4'hA;
        model_reset();
        a1_en = 1'b1; b1_en = 1'b1; a3_en = 1'b1; b3_en = 1'b1;
        #3;
        checks++;
        if ({oe_ab1, oe_ba1, busy1} !== 3'b000) begin
            failures++; $display("FAIL reset_flags1 got %b expected 000", {oe_ab1, oe_ba1, busy1});
        end
        checks++;
        if ({oe_ab3, oe_ba3, busy3} !== 3'b000) begin
            failures++; $display("FAIL reset_flags3 got %b expected 000", {oe_ab3, oe_ba3, busy3});
        end
        checks++;
        if (a1 !== 4'h5 || b1 !== 4'hA) begin
            failures++; $display("FAIL reset_release got a=%h b=%h expected a=5 b=a", a1, b1);
        end
        tick();
        checks++;
        if ({oe_ab1, oe_ba1, busy1} !== 3'b000) begin
            failures++; $display("FAIL reset_hold got %b expected 000", {oe_ab1, oe_ba1, busy1});
        end
    endtask

    task automatic test_a2b();
        rst_n = 1'b1; en = 1'b1; sel = 1'b1; da = 4'h1;
        apply_ext();
        tick();
        checks++;
        if ({oe_ab1, oe_ba1, busy1} !== 3'b100 || b1 !== 4'h1 || a1 !== 4'h1) begin
            failures++;
            $display("FAIL a2b_first got flags=%b a=%h b=%h expected flags=100 a=1 b=1",
                     {oe_ab1, oe_ba1, busy1}, a1, b1);
        end
        checks++;
        if ({oe_ab3, oe_ba3, busy3} !== 3'b100 || b3 !== 4'h1) begin
            failures++; $display("FAIL a2b_first3 got flags=%b b=%h expected 100 b=1", {oe_ab3, oe_ba3, busy3}, b3);
        end
    endtask

    task automatic test_zero_latency();
        logic [W-1:0] v;
        da = 4'h0;
        #1;
        checks++;
        if (b1 !== 4'h0) begin
            failures++; $display("FAIL follow_zero got b=%h expected 0", b1);
        end
        for (int k = 0; k < 4; k++) begin
            v  = W'($urandom);
            da = v;
            #1;
            checks++;
            if (b1 !== v || b3 !== v) begin
                failures++; $display("FAIL follow_rand got b1=%h b3=%h expected %h", b1, b3, v);
            end
        end
    endtask

    task automatic test_reverse();
        sel = 1'b0; db = 4'h0;
        apply_ext();
        tick();
        checks++;
        if ({oe_ab1, oe_ba1, busy1} !== 3'b001 || b1 !== 4'h0) begin
            failures++; $display("FAIL rev_gap got flags=%b b=%h expected 001 b=0", {oe_ab1, oe_ba1, busy1}, b1);
        end
        tick();
        checks++;
        if ({oe_ab1, oe_ba1, busy1} !== 3'b010 || a1 !== 4'h0) begin
            failures++; $display("FAIL rev_drive got flags=%b a=%h expected 010 a=0", {oe_ab1, oe_ba1, busy1}, a1);
        end
        checks++;
        if (busy3 !== 1'b1) begin
            failures++; $display("FAIL rev_gap3 got busy=%b expected 1", busy3);
        end
        db = 4'h1;
        #1;
        checks++;
        if (a1 !== 4'h1) begin
            failures++; $display("FAIL b2a_follow got a=%h expected 1", a1);
        end
    endtask

    task automatic test_toggle_gap();
        int n, busy_cnt;
        n = 0;
        while (!(oe_ba1 === 1'b1 && oe_ba3 === 1'b1) && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!(oe_ba1 === 1'b1 && oe_ba3 === 1'b1)) begin
            failures++; $display("FAIL settle_b2a got oe_ba1=%b oe_ba3=%b expected 1 1", oe_ba1, oe_ba3);
        end
        busy_cnt = 0;
        sel = 1'b1; apply_ext(); tick();
        if (busy3 === 1'b1) busy_cnt++;
        sel = 1'b0; apply_ext(); tick();
        if (busy3 === 1'b1) busy_cnt++;
        sel = 1'b1; apply_ext(); tick();
        if (busy3 === 1'b1) busy_cnt++;
        sel = 1'b0; apply_ext(); tick();
        checks++;
        if (busy_cnt != 3) begin
            failures++; $display("FAIL gap_len got %0d expected 3", busy_cnt);
        end
        checks++;
        if ({oe_ab3, oe_ba3, busy3} !== 3'b010) begin
            failures++; $display("FAIL gap_exit got %b expected 010", {oe_ab3, oe_ba3, busy3});
        end
    endtask

    task automatic test_en_off();
        int n;
        sel = 1'b1; apply_ext();
        n = 0;
        while (oe_ab1 !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (oe_ab1 !== 1'b1) begin
            failures++; $display("FAIL settle_a2b got oe_ab1=%b expected 1", oe_ab1);
        end
        en = 1'b0; da = 4'h9; apply_ext();
        tick();
        checks++;
        if ({oe_ab1, oe_ba1, busy1} !== 3'b000 || {oe_ab3, oe_ba3, busy3} !== 3'b000) begin
            failures++;
            $display("FAIL en_off got flags1=%b flags3=%b expected 000 000", {oe_ab1, oe_ba1, busy1}, {oe_ab3, oe_ba3, busy3});
        end
        checks++;
        if (a1 !== 4'h9) begin
            failures++; $display("FAIL en_off_release got a=%h expected 9", a1);
        end
    endtask

    task automatic test_reset_mid_turn();
        en = 1'b1; sel = 1'b1; apply_ext();
        tick();
        sel = 1'b0; apply_ext();
        tick();
        checks++;
        if (busy1 !== 1'b1 || busy3 !== 1'b1) begin
            failures++; $display("FAIL pre_rst_turn got busy1=%b busy3=%b expected 1 1", busy1, busy3);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        apply_ext();
        #1;
        checks++;
        if ({oe_ab1, oe_ba1, busy1} !== 3'b000 || {oe_ab3, oe_ba3, busy3} !== 3'b000) begin
            failures++;
            $display("FAIL async_rst got flags1=%b flags3=%b expected 000 000", {oe_ab1, oe_ba1, busy1}, {oe_ab3, oe_ba3, busy3});
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic prev_ab[2], prev_ba[2];
        logic [2:0] f;
        for (int i = 0; i < 2; i++) begin
            prev_ab[i] = obs_flags(i)[2];
            prev_ba[i] = obs_flags(i)[1];
        end
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (rst_n == 1'b0) begin
                rst_n = 1'b1;
            end else if ($urandom_range(49) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            en = ($urandom_range(9) != 0);
            if ($urandom_range(4) == 0) sel = ~sel;
            da = W'($urandom);
            db = W'($urandom);
            apply_ext();
            #1;
            for (int i = 0; i < 2; i++) begin
                f = obs_flags(i);
                checks++;
                if (f !== exp_flags(i)) begin
                    failures++; $display("FAIL rnd_flags dut%0d cycle %0d got %b expected %b", i, c, f, exp_flags(i));
                end
                checks++;
                if (f[2] === 1'b1 && f[1] === 1'b1) begin
                    failures++; $display("FAIL rnd_mutex dut%0d cycle %0d got oe_ab=1 oe_ba=1 expected not both", i, c);
                end
                checks++;
                if ((prev_ab[i] === 1'b1 && f[1] === 1'b1) || (prev_ba[i] === 1'b1 && f[2] === 1'b1)) begin
                    failures++; $display("FAIL rnd_noturn dut%0d cycle %0d got direct swap expected TURN between", i, c);
                end
                prev_ab[i] = f[2];
                prev_ba[i] = f[1];
            end
            if (m_drv[0] == 1) begin
                checks++;
                if (b1 !== da) begin
                    failures++; $display("FAIL rnd_data_ab1 cycle %0d got %h expected %h", c, b1, da);
                end
            end else if (m_drv[0] == -1) begin
                checks++;
                if (a1 !== db) begin
                    failures++; $display("FAIL rnd_data_ba1 cycle %0d got %h expected %h", c, a1, db);
                end
            end
            if (m_drv[1] == 1) begin
                checks++;
                if (b3 !== da) begin
                    failures++; $display("FAIL rnd_data_ab3 cycle %0d got %h expected %h", c, b3, da);
                end
            end else if (m_drv[1] == -1) begin
                checks++;
                if (a3 !== db) begin
                    failures++; $display("FAIL rnd_data_ba3 cycle %0d got %h expected %h", c, a3, db);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_a2b();
        test_zero_latency();
        test_reverse();
        test_toggle_gap();
        test_en_off();
        test_reset_mid_turn();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
